// File: rtl/bounce_generator_pkg.sv
// Shared types and constants for the switch-bounce emulator.
//   state_e      : FSM states (IDLE, BOUNCE)
//   LFSR_WIDTH   : width of the jitter LFSR
//   LFSR_TAPS    : Galois feedback mask
//   DEFAULT_SEED : LFSR reset value used when none is given
//   lfsr_fix_seed: maps an all-zero seed (LFSR lock-up) to 1
package bounce_generator_pkg;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_fix_seed(input logic [LFSR_WIDTH-1:0] seed);
    return (seed == '0) ? LFSR_WIDTH'(1) : seed;
  endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit Galois LFSR, free-running every clock cycle out of reset.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset, loads SEED (0 replaced by 1)
//   lfsr_o  : current LFSR state
module lfsr_galois16
  import bounce_generator_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [LFSR_WIDTH-1:0] lfsr_o
);

  localparam logic [LFSR_WIDTH-1:0] ResetVal = lfsr_fix_seed(SEED);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form: feedback from bit 0 into the tap mask.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= ResetVal;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Switch-bounce emulator. A change on clean_input starts a window of BOUNCE_CYCLES cycles in
// which noisy_output toggles at pseudo-random spacings (MIN_PULSE + LFSR jitter), after which
// it settles to the new level. A reversal mid-window restarts the window length only.
// Optional macro BOUNCE_GENERATOR_COUNT_EN adds bounce_count (toggles in the current window,
// saturating at 255).
// Ports:
//   clk          : clock
//   reset_n      : asynchronous active-low reset
//   en           : 1 = emulate bounce, 0 = pass clean_input through with 1-cycle latency
//   clean_input  : ideal switch level
//   noisy_output : bouncing switch level
//   bounce_count : (BOUNCE_GENERATOR_COUNT_EN only) toggles in the current/last window
//   bouncing     : high while inside the bounce window
module bounce_generator
  import bounce_generator_pkg::*;
#(
  parameter int unsigned           BOUNCE_CYCLES = 1_000_000,
  parameter int unsigned           MIN_PULSE     = 4,
  parameter int unsigned           JITTER_BITS   = 4,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clean_input,
  output logic       noisy_output,
`ifdef BOUNCE_GENERATOR_COUNT_EN
  output logic [7:0] bounce_count,
`endif
  output logic       bouncing
);

  localparam int unsigned WinW = $clog2(BOUNCE_CYCLES);
  // Largest interval is MIN_PULSE + 2^JITTER_BITS - 1.
  localparam int unsigned GapW = $clog2(MIN_PULSE + 2 ** JITTER_BITS);
  localparam logic [WinW-1:0] WinLast = WinW'(BOUNCE_CYCLES - 1);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [GapW-1:0]       interval;

  state_e          state_q, state_d;
  logic            target_q, target_d;
  logic            noisy_q, noisy_d;
  logic [WinW-1:0] win_q, win_d;
  logic [GapW-1:0] gap_q, gap_d;

  lfsr_galois16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .lfsr_o (lfsr)
  );

  always_comb begin
    interval = GapW'(MIN_PULSE) + GapW'(lfsr[JITTER_BITS-1:0]);
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    noisy_d  = noisy_q;
    win_d    = win_q;
    gap_d    = gap_q;

    if (!en) begin
      state_d  = IDLE;
      noisy_d  = clean_input;
      target_d = clean_input;
      win_d    = '0;
      gap_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          noisy_d = target_q;
          if (clean_input != target_q) begin
            target_d = clean_input;
            noisy_d  = ~noisy_q;
            win_d    = '0;
            gap_d    = interval;
            state_d  = BOUNCE;
          end
        end
        BOUNCE: begin
          win_d = win_q + 1'b1;
          gap_d = gap_q - 1'b1;
          if (gap_q == GapW'(1)) begin
            noisy_d = ~noisy_q;
            gap_d   = interval;
          end
          // A reversal only restarts the window; the toggle schedule carries on.
          if (clean_input != target_q) begin
            target_d = clean_input;
            win_d    = '0;
          end else if (win_q == WinLast) begin
            noisy_d = target_q;
            win_d   = '0;
            gap_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      noisy_q  <= 1'b0;
      win_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      noisy_q  <= noisy_d;
      win_q    <= win_d;
      gap_q    <= gap_d;
    end
  end

  assign noisy_output = noisy_q;
  assign bouncing     = (state_q == BOUNCE);

`ifdef BOUNCE_GENERATOR_COUNT_EN
  logic [7:0] count_q, count_d;
  logic       win_entry, win_toggle;

  always_comb begin
    win_entry  = en && (state_q == IDLE) && (clean_input != target_q);
    // A toggle coinciding with the settle cycle is overridden, so it is not counted.
    win_toggle = en && (state_q == BOUNCE) && (gap_q == GapW'(1)) &&
                 !((clean_input == target_q) && (win_q == WinLast));
    count_d    = count_q;
    if (win_entry) begin
      count_d = 8'd1;
    end else if (win_toggle && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bounce_count = count_q;
`else
  // Toggle counter not built; the interface ends at bouncing.
`endif

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator (BOUNCE_CYCLES=100, MIN_PULSE=3, JITTER_BITS=2).
// The reference model tracks absolute cycle stamps for the next toggle and the settle point.
module tb_bounce_generator;

  localparam int BC = 100;
  localparam int MP = 3;
  localparam int JB = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;
  logic clean_input = 1'b0;
  logic noisy_output, bouncing;
`ifdef BOUNCE_GENERATOR_COUNT_EN
  logic [7:0] bounce_count;
  logic       sat_clean = 1'b0;
  logic       sat_noisy, sat_bouncing;
  logic [7:0] sat_count;
`endif

  always #5 clk = ~clk;

  bounce_generator #(
    .BOUNCE_CYCLES(BC),
    .MIN_PULSE    (MP),
    .JITTER_BITS  (JB)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .clean_input (clean_input),
    .noisy_output(noisy_output),
`ifdef BOUNCE_GENERATOR_COUNT_EN
    .bounce_count(bounce_count),
`endif
    .bouncing    (bouncing)
  );

`ifdef BOUNCE_GENERATOR_COUNT_EN
  bounce_generator #(
    .BOUNCE_CYCLES(1000),
    .MIN_PULSE    (1),
    .JITTER_BITS  (1)
  ) u_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (1'b1),
    .clean_input (sat_clean),
    .noisy_output(sat_noisy),
    .bounce_count(sat_count),
    .bouncing    (sat_bouncing)
  );
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  bit          m_bounce, m_target, m_noisy;
  int          m_next_tog, m_settle_at, m_cnt;

  // Toggle-spacing monitor (observes the DUT, used by scenario checks)
  int   last_tog, sp_min, sp_max, n_tog;
  logic prev_noisy = 1'b0;

  task automatic model_reset();
    m_lfsr      = 16'hACE1;
    m_bounce    = 1'b0;
    m_target    = 1'b0;
    m_noisy     = 1'b0;
    m_next_tog  = 0;
    m_settle_at = 0;
    m_cnt       = 0;
  endtask

  task automatic track_reset();
    last_tog = -1;
    sp_min   = 1000;
    sp_max   = 0;
    n_tog    = 0;
  endtask

  task automatic model_edge();
    int iv;
    bit rev;
    if (reset_n !== 1'b1) begin
      model_reset();
      return;
    end
    iv = MP + int'(m_lfsr[JB-1:0]);
    if (!en) begin
      m_bounce = 1'b0;
      m_noisy  = clean_input;
      m_target = clean_input;
    end else if (!m_bounce) begin
      if (clean_input != m_target) begin
        m_target    = clean_input;
        m_noisy     = !m_noisy;
        m_bounce    = 1'b1;
        m_next_tog  = cyc + iv;
        m_settle_at = cyc + BC;
        m_cnt       = 1;
      end
    end else begin
      rev = (clean_input != m_target);
      if (rev) begin
        m_target    = clean_input;
        m_settle_at = cyc + BC;
      end
      if (!rev && cyc == m_settle_at) begin
        m_noisy  = m_target;
        m_bounce = 1'b0;
      end else if (cyc == m_next_tog) begin
        m_noisy    = !m_noisy;
        m_next_tog = cyc + iv;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (noisy_output !== prev_noisy && bouncing === 1'b1) begin
      if (last_tog >= 0) begin
        if (cyc - last_tog < sp_min) sp_min = cyc - last_tog;
        if (cyc - last_tog > sp_max) sp_max = cyc - last_tog;
      end
      last_tog = cyc;
      n_tog++;
    end
    prev_noisy = noisy_output;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clean_input = 1'b1;
    model_reset();
    repeat (3) tick();
    checks++;
    if (noisy_output !== 1'b0 || bouncing !== 1'b0) begin
      failures++;
      $display("FAIL reset_values noisy=%b bouncing=%b expected 0 0", noisy_output, bouncing);
    end
    clean_input = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (noisy_output !== 1'b0 || bouncing !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet cyc=%0d noisy=%b bouncing=%b expected 0 0",
                 cyc, noisy_output, bouncing);
      end
    end
  endtask

  task automatic test_rising();
    int hi;
    track_reset();
    clean_input = 1'b1;
    tick();
    checks++;
    if (noisy_output !== 1'b1 || bouncing !== 1'b1) begin
      failures++;
      $display("FAIL rising_first noisy=%b bouncing=%b expected 1 1", noisy_output, bouncing);
    end
    hi = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bouncing === 1'b1) hi++;
      checks++;
      if (noisy_output !== m_noisy || bouncing !== m_bounce) begin
        failures++;
        $display("FAIL rising_model cyc=%0d noisy=%b bouncing=%b expected %b %b",
                 cyc, noisy_output, bouncing, m_noisy, m_bounce);
      end
    end
    checks++;
    if (hi != BC) begin
      failures++;
      $display("FAIL rising_window bouncing_cycles=%0d expected %0d", hi, BC);
    end
    checks++;
    if (noisy_output !== 1'b1 || bouncing !== 1'b0) begin
      failures++;
      $display("FAIL rising_settle noisy=%b bouncing=%b expected 1 0", noisy_output, bouncing);
    end
    checks++;
    if (sp_max == 0 || sp_min < MP || sp_max > MP + (1 << JB) - 1) begin
      failures++;
      $display("FAIL rising_spacing min=%0d max=%0d expected within [%0d,%0d]",
               sp_min, sp_max, MP, MP + (1 << JB) - 1);
    end
  endtask

  task automatic test_reversal();
    int n;
    clean_input = 1'b0;
    repeat (120) tick();
    track_reset();
    clean_input = 1'b1;
    tick();
    repeat (50) tick();
    clean_input = 1'b0;
    tick();
    checks++;
    if (bouncing !== 1'b1) begin
      failures++;
      $display("FAIL reversal_stays bouncing=%b expected 1", bouncing);
    end
    n = 0;
    while (bouncing === 1'b1 && n < 200) begin
      tick();
      n++;
      checks++;
      if (noisy_output !== m_noisy || bouncing !== m_bounce) begin
        failures++;
        $display("FAIL reversal_model cyc=%0d noisy=%b bouncing=%b expected %b %b",
                 cyc, noisy_output, bouncing, m_noisy, m_bounce);
      end
    end
    checks++;
    if (n != BC || noisy_output !== 1'b0) begin
      failures++;
      $display("FAIL reversal_settle after=%0d noisy=%b expected %0d 0", n, noisy_output, BC);
    end
    checks++;
    if (sp_max == 0 || sp_min < MP || sp_max > MP + (1 << JB) - 1) begin
      failures++;
      $display("FAIL reversal_spacing min=%0d max=%0d", sp_min, sp_max);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] pat;
    pat = 4'b0110;
    en = 1'b0;
    clean_input = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      clean_input = pat[3-i];
      tick();
      checks++;
      if (noisy_output !== pat[3-i] || bouncing !== 1'b0) begin
        failures++;
        $display("FAIL bypass_pattern step=%0d noisy=%b bouncing=%b expected %b 0",
                 i, noisy_output, bouncing, pat[3-i]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_en_drop();
    clean_input = 1'b1;
    tick();
    repeat (20) tick();
    checks++;
    if (bouncing !== 1'b1) begin
      failures++;
      $display("FAIL endrop_window bouncing=%b expected 1", bouncing);
    end
    en = 1'b0;
    tick();
    checks++;
    if (bouncing !== 1'b0 || noisy_output !== 1'b1) begin
      failures++;
      $display("FAIL endrop_abort noisy=%b bouncing=%b expected 1 0", noisy_output, bouncing);
    end
    en = 1'b1;
    tick();
    checks++;
    if (bouncing !== 1'b0 || noisy_output !== m_noisy) begin
      failures++;
      $display("FAIL endrop_resume noisy=%b bouncing=%b expected %b 0",
               noisy_output, bouncing, m_noisy);
    end
  endtask

  task automatic test_async_reset();
    int k;
    clean_input = 1'b0;
    repeat (120) tick();
    clean_input = 1'b1;
    tick();
    repeat (40) tick();
    k = 0;
    while (noisy_output !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (noisy_output !== 1'b0 || bouncing !== 1'b0) begin
      failures++;
      $display("FAIL async_reset noisy=%b bouncing=%b expected 0 0", noisy_output, bouncing);
    end
    model_reset();
    prev_noisy = 1'b0;
    clean_input = 1'b0;
    repeat (2) tick();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) < 3) clean_input = ~clean_input;
      en = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (noisy_output !== m_noisy || bouncing !== m_bounce) begin
        failures++;
        $display("FAIL random_model cyc=%0d noisy=%b bouncing=%b expected %b %b",
                 cyc, noisy_output, bouncing, m_noisy, m_bounce);
      end
`ifdef BOUNCE_GENERATOR_COUNT_EN
      checks++;
      if (int'(bounce_count) != m_cnt) begin
        failures++;
        $display("FAIL random_count cyc=%0d count=%0d expected %0d", cyc, bounce_count, m_cnt);
      end
`endif
    end
    en = 1'b1;
  endtask

`ifdef BOUNCE_GENERATOR_COUNT_EN
  task automatic test_count();
    // Fresh window from a settled low level; compare against toggles seen on the pin.
    clean_input = 1'b0;
    repeat (120) tick();
    track_reset();
    clean_input = 1'b1;
    repeat (110) tick();
    checks++;
    if (int'(bounce_count) != n_tog) begin
      failures++;
      $display("FAIL count_window count=%0d expected %0d", bounce_count, n_tog);
    end
    sat_clean = 1'b1;
    repeat (1010) tick();
    checks++;
    if (sat_count !== 8'd255 || sat_bouncing !== 1'b0 || sat_noisy !== 1'b1) begin
      failures++;
      $display("FAIL count_saturate count=%0d bouncing=%b noisy=%b expected 255 0 1",
               sat_count, sat_bouncing, sat_noisy);
    end
  endtask
`endif

  initial begin
    track_reset();
    model_reset();
    test_reset();
    test_rising();
    test_reversal();
    test_bypass();
    test_en_drop();
    test_async_reset();
    test_random();
`ifdef BOUNCE_GENERATOR_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Switch-bounce emulator: takes a clean level and produces a contact-bounce waveform on the output.
- Output toggles at pseudo-random intervals for a fixed window, then settles to the new level.
- It is the driving end for debouncer blocks. Used in benches and on-board self-test to feed debouncer/edge-detector inputs from a clean stimulus.

Parameters:
- BOUNCE_CYCLES, 1_000_000, length of the bounce window in clk cycles; must be >= 2.
- MIN_PULSE, 4, minimum cycles between output toggles inside the window; must be >= 1.
- JITTER_BITS, 4, number of LFSR bits added to MIN_PULSE to form each toggle interval.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  1 = emulate bounce; 0 = bypass (clean level passed through)
- clean_input  input  1  ideal switch level
- noisy_output  output  1  bouncing switch level
- bouncing  output  1  high while in the bounce window

Behaviour:
- Single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - noisy_output=0, bouncing=0.
  - internal target=0, state=IDLE, window_cnt=0, gap_cnt=0, lfsr=LFSR_SEED (or 1 if the seed is 0).
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle when not in reset, including in bypass.
- interval = MIN_PULSE + lfsr[JITTER_BITS-1:0]; counter widths are sized by $clog2.
- States are IDLE and BOUNCE; bouncing = (state==BOUNCE).
- IDLE:
  - noisy_output holds target.
  - When clean_input != target at a clk edge: target<=clean_input, noisy_output<=~noisy_output (first bounce edge, 1-cycle latency), window_cnt<=0, gap_cnt<=interval, state<=BOUNCE.
- BOUNCE, evaluated each cycle:
  - window_cnt++ and gap_cnt--.
  - If gap_cnt==1: noisy_output toggles and gap_cnt<=interval.
  - If window_cnt==BOUNCE_CYCLES-1: noisy_output<=target, state<=IDLE. This has priority over a toggle in the same cycle.
- Reversal mid-window (clean_input != target while in BOUNCE):
  - target<=clean_input and window_cnt<=0.
  - The toggle schedule continues unchanged; there is no forced toggle.
  - Reversal has priority over window end in the same cycle.
- Consequences:
  - Every toggle-to-toggle spacing inside the window lies in [MIN_PULSE, MIN_PULSE+2^JITTER_BITS-1].
  - Settling occurs exactly BOUNCE_CYCLES cycles after the last target change.
- en=0 (bypass):
  - state<=IDLE, noisy_output<=clean_input, target<=clean_input (1-cycle latency), counters cleared.
  - Deasserting en mid-bounce aborts the window on the next edge.
- reset_n low at any time: immediate return to reset values.

Optional Feature:
- Macro: BOUNCE_GENERATOR_COUNT_EN.
- Defined: adds output port bounce_count, 8 bits.
  - Cleared to 0 on reset and on each IDLE->BOUNCE entry.
  - Increments on every noisy_output toggle inside a window, including the first and excluding the final settle write.
  - Saturates at 255 and holds its value in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bounce_generator_pkg holds:
  - state enum (IDLE, BOUNCE)
  - LFSR_WIDTH=16 and LFSR_TAPS=16'hB400
  - DEFAULT_SEED
- Sub-module lfsr_galois16, with ports clk, reset_n and parameter SEED, outputs the 16-bit state.
- The FSM and counters stay in bounce_generator.

Test Plan:
- Settings for all scenarios: BOUNCE_CYCLES=100, MIN_PULSE=3, JITTER_BITS=2 unless stated.
- Reset: hold reset_n=0 with clean_input=1 -> noisy_output=0, bouncing=0. Release with clean_input=0 -> no toggles for 200 cycles.
- Rising event, clean_input 0->1 sampled at edge t:
  - noisy_output=1 at t+1, bouncing=1 for cycles t+1..t+100.
  - Every toggle spacing in [3,6].
  - noisy_output=1 and bouncing=0 from t+101 onward.
- Reversal: clean_input returns to 0 at window_cnt=50 -> bouncing stays high, output settles to 0 exactly 100 cycles after the reversal edge, toggle spacing still in [3,6].
- Bypass: en=0, clean_input pattern 0,1,1,0 -> noisy_output shows the same pattern one cycle later, bouncing=0 throughout. Drop en mid-window -> bouncing=0 the next cycle.
- Async reset mid-bounce: assert reset_n at window_cnt=40 -> noisy_output=0 and bouncing=0 without waiting for a clk edge.
- With BOUNCE_GENERATOR_COUNT_EN:
  - bounce_count equals the bench-counted toggles per window.
  - With MIN_PULSE=1, JITTER_BITS=1, BOUNCE_CYCLES=1000 -> bounce_count=255 (saturated).
